sample_uart_tx: RTL

//  Serial transmitter at the read side of the scope sample FIFO. Accepts one DSIZE-bit

---
 rtl/sample_uart_tx.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/sample_uart_tx.sv
// Two-byte 8N1 UART transmitter for scope samples: each sample goes out as a
// HI byte {1, s[13:7]} followed by a LO byte {0, s[6:0]}, with bit 7 as the sync flag.
module sample_uart_tx #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200,
  parameter int DSIZE    = 12
) (
  input  logic             CLK100MHz,
  input  logic             rst_n,
  input  logic             TxD_start,
  input  logic [DSIZE-1:0] TxD_data,
  output logic             TxD_busy,
  output logic             TxD,
  output logic             tx_done,
  output logic [1:0]       fsm_state
);

  localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  if (DSIZE < 8 || DSIZE > 14) begin : g_bad_dsize
    $error("sample_uart_tx: DSIZE must be within 8..14");
  end

  if (DIV < 1) begin : g_bad_div
    $error("sample_uart_tx: BAUD too high for CLK_FREQ");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  localparam logic SEL_HI = 1'b1;
  localparam logic SEL_LO = 1'b0;

  state_t        state, state_nxt;
  logic [CW-1:0] baud_cnt, baud_cnt_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic          byte_sel, byte_sel_nxt;
  logic [13:0]   sample, sample_nxt;
  logic          tx_reg, tx_nxt;
  logic          busy_reg, busy_nxt;
  logic          done_reg, done_nxt;

  logic [7:0]    cur_byte;
  logic [2:0]    bit_idx_inc;
  logic          bit_end;

  assign cur_byte    = (byte_sel == SEL_HI) ? {1'b1, sample[13:7]} : {1'b0, sample[6:0]};
  assign bit_idx_inc = bit_idx + 3'd1;
  assign bit_end     = (baud_cnt == CNT_MAX);

  always_ff @(posedge CLK100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_sel <= SEL_HI;
      sample   <= '0;
      tx_reg   <= 1'b1;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      byte_sel <= byte_sel_nxt;
      sample   <= sample_nxt;
      tx_reg   <= tx_nxt;
      busy_reg <= busy_nxt;
      done_reg <= done_nxt;
    end
  end

  // Handshake: TxD_start is the request and !TxD_busy the ready; a sample is
  // taken on an edge where both hold, and TxD_busy rises on that same edge.
  // The line register is loaded with the level of the upcoming bit at each
  // bit boundary, so TxD changes exactly once per DIV clocks.
  always_comb begin
    state_nxt    = state;
    baud_cnt_nxt = baud_cnt;
    bit_idx_nxt  = bit_idx;
    byte_sel_nxt = byte_sel;
    sample_nxt   = sample;
    tx_nxt       = tx_reg;
    busy_nxt     = busy_reg;
    done_nxt     = 1'b0;

    unique case (state)
      S_IDLE: begin
        tx_nxt       = 1'b1;
        busy_nxt     = 1'b0;
        baud_cnt_nxt = '0;
        if (TxD_start) begin
          sample_nxt   = 14'(TxD_data);
          byte_sel_nxt = SEL_HI;
          bit_idx_nxt  = '0;
          state_nxt    = S_START;
          tx_nxt       = 1'b0;
          busy_nxt     = 1'b1;
        end
      end

      S_START: begin
        if (bit_end) begin
          baud_cnt_nxt = '0;
          bit_idx_nxt  = '0;
          state_nxt    = S_DATA;
          tx_nxt       = cur_byte[0];
        end else begin
          baud_cnt_nxt = baud_cnt + CW'(1);
        end
      end

      S_DATA: begin
        if (bit_end) begin
          baud_cnt_nxt = '0;
          if (bit_idx == 3'd7) begin
            state_nxt = S_STOP;
            tx_nxt    = 1'b1;
          end else begin
            bit_idx_nxt = bit_idx_inc;
            tx_nxt      = cur_byte[bit_idx_inc];
          end
        end else begin
          baud_cnt_nxt = baud_cnt + CW'(1);
        end
      end

      S_STOP: begin
        if (bit_end) begin
          baud_cnt_nxt = '0;
          if (byte_sel == SEL_HI) begin
            byte_sel_nxt = SEL_LO;
            state_nxt    = S_START;
            tx_nxt       = 1'b0;
          end else begin
            state_nxt = S_IDLE;
            tx_nxt    = 1'b1;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end
        end else begin
          baud_cnt_nxt = baud_cnt + CW'(1);
        end
      end

      default: begin
        state_nxt = S_IDLE;
        tx_nxt    = 1'b1;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  assign TxD       = tx_reg;
  assign TxD_busy  = busy_reg;
  assign tx_done   = done_reg;
  assign fsm_state = state;

endmodule
